// File: rtl/a2d_spi_responder.sv
// rtl/a2d_spi_responder.sv - SPI responder modelling a three-channel A2D with one-frame response pipeline
module a2d_spi_responder #(
    parameter logic [2:0] LFT_CH  = 3'd0,
    parameter logic [2:0] RGHT_CH = 3'd4,
    parameter logic [2:0] BATT_CH = 3'd5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        SS_n,
    input  logic        SCLK,
    input  logic        MOSI,
    output logic        MISO,
    input  logic [11:0] ld_cell_lft,
    input  logic [11:0] ld_cell_rght,
    input  logic [11:0] batt,
    output logic [2:0]  cmd_ch,
    output logic [7:0]  conv_cnt,
    output logic        frame_err
);

    typedef enum logic [1:0] {WAIT_IDLE, IDLE, XFER} state_t;

    state_t      state, state_nxt;
    logic        ss_s1, ss_s2, ss_d;
    logic        sclk_s1, sclk_s2, sclk_d;
    logic        mosi_s1, mosi_s2;
    logic [1:0]  settle_cnt;
    logic [15:0] tx_shift;
    logic [15:0] rx_shift;
    logic [4:0]  bit_cnt;
    logic [11:0] result;
    logic [11:0] sel_val;
    logic        ss_fall, ss_rise, sclk_rise, sclk_fall;
    logic        load, rx_en, tx_en, done, abort;

    assign ss_fall   = ss_d & ~ss_s2;
    assign ss_rise   = ~ss_d & ss_s2;
    assign sclk_fall = sclk_d & ~sclk_s2;
    assign sclk_rise = ~sclk_d & sclk_s2;

    // Double-flop the SPI pins into clk and keep one more stage for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ss_s1   <= 1'b1;
            ss_s2   <= 1'b1;
            ss_d    <= 1'b1;
            sclk_s1 <= 1'b1;
            sclk_s2 <= 1'b1;
            sclk_d  <= 1'b1;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
        end else begin
            ss_s1   <= SS_n;
            ss_s2   <= ss_s1;
            ss_d    <= ss_s2;
            sclk_s1 <= SCLK;
            sclk_s2 <= sclk_s1;
            sclk_d  <= sclk_s2;
            mosi_s1 <= MOSI;
            mosi_s2 <= mosi_s1;
        end
    end

    // Select the analog value for the channel just addressed; LFT beats RGHT beats BATT on overlap
    always_comb begin
        sel_val = 12'h000;
        if (rx_shift[13:11] == LFT_CH)
            sel_val = ld_cell_lft;
        else if (rx_shift[13:11] == RGHT_CH)
            sel_val = ld_cell_rght;
        else if (rx_shift[13:11] == BATT_CH)
            sel_val = batt;
    end

    // Next-state logic and per-cycle strobes for the datapath
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        rx_en     = 1'b0;
        tx_en     = 1'b0;
        done      = 1'b0;
        abort     = 1'b0;
        case (state)
            // The sync chain holds its reset value for a few cycles, so only trust
            // SS_n high once the chain has refilled from the pin
            WAIT_IDLE: if (settle_cnt == 2'd3 && ss_s2 && ss_d) state_nxt = IDLE;
            IDLE: begin
                if (ss_fall) begin
                    state_nxt = XFER;
                    load      = 1'b1;
                end
            end
            XFER: begin
                if (ss_rise) begin
                    state_nxt = IDLE;
                    if (bit_cnt == 5'd16) done = 1'b1;
                    else                  abort = 1'b1;
                end else begin
                    rx_en = sclk_rise;
                    tx_en = sclk_fall && (bit_cnt != 5'd0);
                end
            end
            default: state_nxt = WAIT_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= WAIT_IDLE;
        else     state <= state_nxt;
    end

    // Shift registers, bit counter, captured result and frame status
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            settle_cnt <= 2'd0;
            tx_shift   <= 16'h0000;
            rx_shift   <= 16'h0000;
            bit_cnt    <= 5'd0;
            result     <= 12'h000;
            cmd_ch     <= 3'd0;
            conv_cnt   <= 8'd0;
            frame_err  <= 1'b0;
        end else begin
            if (state == WAIT_IDLE && settle_cnt != 2'd3)
                settle_cnt <= settle_cnt + 2'd1;
            frame_err <= abort;
            if (load) begin
                tx_shift <= {4'h0, result};
                rx_shift <= 16'h0000;
                bit_cnt  <= 5'd0;
            end
            if (rx_en) begin
                rx_shift <= {rx_shift[14:0], mosi_s2};
                if (bit_cnt != 5'd31) bit_cnt <= bit_cnt + 5'd1;
            end
            if (tx_en)
                tx_shift <= {tx_shift[14:0], 1'b0};
            if (done) begin
                cmd_ch   <= rx_shift[13:11];
                result   <= sel_val;
                conv_cnt <= conv_cnt + 8'd1;
            end
        end
    end

    assign MISO = (state == XFER) ? tx_shift[15] : 1'b0;

endmodule

// File: tb/tb_a2d_spi_responder.sv
// tb/tb_a2d_spi_responder.sv - table-driven bench for a2d_spi_responder
module tb_a2d_spi_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        SS_n = 1'b1;
    logic        SCLK = 1'b1;
    logic        MOSI = 1'b0;
    logic        MISO;
    logic [11:0] ld_cell_lft = 12'h000;
    logic [11:0] ld_cell_rght = 12'h000;
    logic [11:0] batt = 12'h000;
    logic [2:0]  cmd_ch;
    logic [7:0]  conv_cnt;
    logic        frame_err;

    int checks = 0;
    int errors = 0;
    int err_pulses = 0;
    int err_hi = 0;
    int miso_hi = 0;
    logic fe_prev = 1'b0;

    typedef struct {
        logic [15:0] cmd;
        logic [11:0] lft;
        logic [11:0] rght;
        logic [11:0] bat;
        logic [15:0] exp_rd;
        logic [2:0]  exp_ch;
        logic [7:0]  exp_cnt;
    } vec_t;

    vec_t vecs[10];

    a2d_spi_responder dut (
        .clk(clk), .rst(rst), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
        .ld_cell_lft(ld_cell_lft), .ld_cell_rght(ld_cell_rght), .batt(batt),
        .cmd_ch(cmd_ch), .conv_cnt(conv_cnt), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err) err_hi++;
        if (frame_err && !fe_prev) err_pulses++;
        fe_prev = frame_err;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Drive one frame of nbits SCLK cycles, collecting MISO just before each rising edge
    task automatic spi_frame(input logic [15:0] cmd, input int nbits, output logic [15:0] rd);
        rd = 16'h0000;
        SS_n = 1'b0;
        wait_clk(8);
        for (int i = 0; i < nbits; i++) begin
            SCLK = 1'b0;
            MOSI = cmd[15-i];
            wait_clk(8);
            rd[15-i] = MISO;
            if (MISO) miso_hi++;
            SCLK = 1'b1;
            wait_clk(8);
        end
        SS_n = 1'b1;
        wait_clk(10);
    endtask

    function automatic vec_t mk(input logic [15:0] cmd, input logic [11:0] l, input logic [11:0] r,
                                input logic [11:0] b, input logic [15:0] rd, input logic [2:0] ch,
                                input logic [7:0] cnt);
        vec_t v;
        v.cmd = cmd; v.lft = l; v.rght = r; v.bat = b;
        v.exp_rd = rd; v.exp_ch = ch; v.exp_cnt = cnt;
        return v;
    endfunction

    initial begin
        logic [15:0] rd;
        int          p0, h0;

        vecs[0] = mk(16'h0000, 12'hABC, 12'h123, 12'hFFF, 16'h0000, 3'd0, 8'd1);
        vecs[1] = mk(16'h0000, 12'hABC, 12'h123, 12'hFFF, 16'h0ABC, 3'd0, 8'd2);
        vecs[2] = mk(16'h2000, 12'hABC, 12'h123, 12'hFFF, 16'h0ABC, 3'd4, 8'd3);
        vecs[3] = mk(16'h2800, 12'hABC, 12'h123, 12'hFFF, 16'h0123, 3'd5, 8'd4);
        vecs[4] = mk(16'h0000, 12'hABC, 12'h123, 12'hFFF, 16'h0FFF, 3'd0, 8'd5);
        vecs[5] = mk(16'h3800, 12'hABC, 12'h123, 12'hFFF, 16'h0ABC, 3'd7, 8'd6);
        vecs[6] = mk(16'h0000, 12'hABC, 12'h123, 12'hFFF, 16'h0000, 3'd0, 8'd7);
        vecs[7] = mk(16'h0000, 12'h555, 12'h123, 12'hFFF, 16'h0ABC, 3'd0, 8'd8);
        vecs[8] = mk(16'h0000, 12'hABC, 12'h123, 12'hFFF, 16'h0555, 3'd0, 8'd9);
        vecs[9] = mk(16'hC7FF, 12'hABC, 12'h123, 12'hFFF, 16'h0ABC, 3'd0, 8'd10);

        wait_clk(4);
        chk("rst_miso", {31'd0, MISO}, 32'd0);
        chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
        rst = 1'b0;
        wait_clk(10);
        chk("post_rst_cmd_ch", {29'd0, cmd_ch}, 32'd0);
        chk("post_rst_conv_cnt", {24'd0, conv_cnt}, 32'd0);
        chk("post_rst_miso", {31'd0, MISO}, 32'd0);

        for (int i = 0; i < 10; i++) begin
            ld_cell_lft  = vecs[i].lft;
            ld_cell_rght = vecs[i].rght;
            batt         = vecs[i].bat;
            spi_frame(vecs[i].cmd, 16, rd);
            chk($sformatf("vec%0d_rd", i), {16'd0, rd}, {16'd0, vecs[i].exp_rd});
            chk($sformatf("vec%0d_cmd_ch", i), {29'd0, cmd_ch}, {29'd0, vecs[i].exp_ch});
            chk($sformatf("vec%0d_conv_cnt", i), {24'd0, conv_cnt}, {24'd0, vecs[i].exp_cnt});
        end
        chk("no_err_in_table", err_pulses, 0);

        // Aborted frame after 9 SCLK rises
        p0 = err_pulses; h0 = err_hi;
        spi_frame(16'h2800, 9, rd);
        chk("short_err_pulses", err_pulses - p0, 1);
        chk("short_err_width", err_hi - h0, 1);
        chk("short_conv_cnt", {24'd0, conv_cnt}, 32'd10);
        chk("short_cmd_ch", {29'd0, cmd_ch}, 32'd0);
        spi_frame(16'h0000, 16, rd);
        chk("after_short_rd", {16'd0, rd}, 32'h0ABC);
        chk("after_short_cnt", {24'd0, conv_cnt}, 32'd11);

        // Reset in the middle of a frame with SS_n held low
        SS_n = 1'b0;
        wait_clk(8);
        for (int i = 0; i < 3; i++) begin
            SCLK = 1'b0; wait_clk(8);
            SCLK = 1'b1; wait_clk(8);
        end
        rst = 1'b1;
        wait_clk(3);
        chk("midrst_conv_cnt", {24'd0, conv_cnt}, 32'd0);
        chk("midrst_cmd_ch", {29'd0, cmd_ch}, 32'd0);
        rst = 1'b0;
        p0 = err_pulses; miso_hi = 0;
        ld_cell_lft = 12'hFFF;
        for (int i = 0; i < 5; i++) begin
            SCLK = 1'b0; MOSI = 1'b1; wait_clk(8);
            if (MISO) miso_hi++;
            SCLK = 1'b1; wait_clk(8);
        end
        SS_n = 1'b1;
        wait_clk(12);
        chk("midrst_miso_quiet", miso_hi, 0);
        chk("midrst_no_err", err_pulses - p0, 0);
        chk("midrst_cnt_hold", {24'd0, conv_cnt}, 32'd0);
        spi_frame(16'h2800, 16, rd);
        chk("midrst_first_rd", {16'd0, rd}, 32'h0000);
        spi_frame(16'h2800, 16, rd);
        chk("midrst_batt_rd", {16'd0, rd}, 32'h0FFF);
        chk("midrst_cmd_ch", {29'd0, cmd_ch}, 32'd5);
        chk("midrst_conv_cnt2", {24'd0, conv_cnt}, 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
